multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and emits per-cycle datapath strobes instead of static one-hot class flags. It handshakes with a shared instruction/data memory, resolves branches from the ALU zero flag and supports halt/resume. It also flags illegal opcodes and keeps a retired-instruction counter; it sits between the instruction register and the datapath.

---
 rtl/multicycle_control_unit_pkg.sv | 28 ++
 rtl/multicycle_control_unit_retire_counter.sv | 27 ++
 rtl/multicycle_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// pc_src mux encodings and the default opcode map / counter width.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;  // branch target
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;  // jump target

    localparam int DEF_OPCODE_W = 6;
    localparam int DEF_OP_ALU   = 0;
    localparam int DEF_OP_J     = 2;
    localparam int DEF_OP_BEQ   = 4;
    localparam int DEF_OP_ADDI  = 8;
    localparam int DEF_OP_LW    = 35;
    localparam int DEF_OP_SW    = 43;
    localparam int DEF_OP_HALT  = 63;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/multicycle_control_unit_retire_counter.sv
// Saturating retired-instruction counter.
// Ports: clk, reset (async, active-high), inc (count one this cycle),
//        count (current value; sticks at all-ones).
module mcu_retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counter register: increments on request until it reaches all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, emitting per-cycle datapath strobes.
// Ports:
//   clk, reset              clock, async active-high reset
//   opcode                  IR opcode field (used from DECODE onward)
//   alu_zero, mem_ready     ALU zero flag, memory access completion
//   resume                  leave HALTED
//   mem_read..mem_to_reg    datapath strobes (Moore, some gated by inputs)
//   halted, illegal         status: halted state, unknown-opcode pulse
//   retired                 saturating count of completed instructions
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int OP_ALU   = DEF_OP_ALU,
    parameter int OP_J     = DEF_OP_J,
    parameter int OP_BEQ   = DEF_OP_BEQ,
    parameter int OP_ADDI  = DEF_OP_ADDI,
    parameter int OP_LW    = DEF_OP_LW,
    parameter int OP_SW    = DEF_OP_SW,
    parameter int OP_HALT  = DEF_OP_HALT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src_imm,
    output logic                alu_op_rtype,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [OPCODE_W-1:0] OPC_ALU  = OPCODE_W'(OP_ALU);
    localparam logic [OPCODE_W-1:0] OPC_J    = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] OPC_BEQ  = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_ADDI = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OPC_LW   = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW   = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_HALT = OPCODE_W'(OP_HALT);

    state_t state_r;
    state_t next_state_s;
    logic   retire_inc_s;

    logic is_alu_s, is_j_s, is_beq_s, is_addi_s, is_lw_s, is_sw_s, is_halt_s;
    logic is_known_s;

    assign is_alu_s   = (opcode == OPC_ALU);
    assign is_j_s     = (opcode == OPC_J);
    assign is_beq_s   = (opcode == OPC_BEQ);
    assign is_addi_s  = (opcode == OPC_ADDI);
    assign is_lw_s    = (opcode == OPC_LW);
    assign is_sw_s    = (opcode == OPC_SW);
    assign is_halt_s  = (opcode == OPC_HALT);
    assign is_known_s = is_alu_s | is_j_s | is_beq_s | is_addi_s | is_lw_s | is_sw_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and strobe decode; everything is forced low while reset is
    // high so the FETCH read request cannot leak out during reset.
    always_comb begin
        next_state_s = state_r;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        alu_src_imm  = 1'b0;
        alu_op_rtype = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        retire_inc_s = 1'b0;
        if (reset) begin
            next_state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        next_state_s = ST_DECODE;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (is_halt_s) begin
                        retire_inc_s = 1'b1;
                        next_state_s = ST_HALTED;
                    end else if (is_known_s) begin
                        next_state_s = ST_EXEC;
                    end else begin
                        illegal      = 1'b1;
                        next_state_s = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_s) begin
                        alu_op_rtype = 1'b1;
                        next_state_s = ST_WB;
                    end else if (is_addi_s) begin
                        alu_src_imm  = 1'b1;
                        next_state_s = ST_WB;
                    end else if (is_lw_s || is_sw_s) begin
                        alu_src_imm  = 1'b1;
                        next_state_s = ST_MEM;
                    end else if (is_beq_s) begin
                        pc_write     = alu_zero;
                        pc_src       = PC_SRC_BRANCH;
                        retire_inc_s = 1'b1;
                        next_state_s = ST_FETCH;
                    end else if (is_j_s) begin
                        pc_write     = 1'b1;
                        pc_src       = PC_SRC_JUMP;
                        retire_inc_s = 1'b1;
                        next_state_s = ST_FETCH;
                    end else begin
                        // Opcode disturbed after DECODE: abandon the instruction.
                        next_state_s = ST_FETCH;
                    end
                end
                ST_MEM: begin
                    iord = 1'b1;
                    if (is_lw_s) begin
                        mem_read = 1'b1;
                    end else if (is_sw_s) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read = 1'b0;
                    end
                    if (mem_ready) begin
                        if (is_lw_s) begin
                            next_state_s = ST_WB;
                        end else begin
                            retire_inc_s = is_sw_s;
                            next_state_s = ST_FETCH;
                        end
                    end else begin
                        next_state_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = is_lw_s;
                    retire_inc_s = 1'b1;
                    next_state_s = ST_FETCH;
                end
                ST_HALTED: begin
                    halted = 1'b1;
                    if (resume) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_HALTED;
                    end
                end
                default: begin
                    next_state_s = ST_FETCH;
                end
            endcase
        end
    end

    mcu_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire_inc_s),
        .count (retired)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Outputs are packed into a
// 13-bit vector {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
// alu_src_imm, alu_op_rtype, reg_write, mem_to_reg, halted, illegal} and
// compared cycle by cycle against hand-written expectations.
module tb_multicycle_control_unit;

    localparam logic [12:0] E_ZERO  = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_FR    = 13'b1_0_0_1_1_00_0_0_0_0_0_0; // fetch, ready
    localparam logic [12:0] E_FN    = 13'b1_0_0_0_0_00_0_0_0_0_0_0; // fetch, waiting
    localparam logic [12:0] E_DEC   = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_EXALU = 13'b0_0_0_0_0_00_0_1_0_0_0_0;
    localparam logic [12:0] E_EXIMM = 13'b0_0_0_0_0_00_1_0_0_0_0_0;
    localparam logic [12:0] E_BEQ1  = 13'b0_0_0_0_1_01_0_0_0_0_0_0;
    localparam logic [12:0] E_BEQ0  = 13'b0_0_0_0_0_01_0_0_0_0_0_0;
    localparam logic [12:0] E_J     = 13'b0_0_0_0_1_10_0_0_0_0_0_0;
    localparam logic [12:0] E_MLW   = 13'b1_0_1_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_MSW   = 13'b0_1_1_0_0_00_0_0_0_0_0_0;
    localparam logic [12:0] E_WB    = 13'b0_0_0_0_0_00_0_0_1_0_0_0;
    localparam logic [12:0] E_WBLW  = 13'b0_0_0_0_0_00_0_0_1_1_0_0;
    localparam logic [12:0] E_HLT   = 13'b0_0_0_0_0_00_0_0_0_0_1_0;
    localparam logic [12:0] E_ILL   = 13'b0_0_0_0_0_00_0_0_0_0_0_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        sreset;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        resume;

    logic        mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_imm, alu_op_rtype, reg_write, mem_to_reg, halted, illegal;
    logic [15:0] retired;

    logic        sm_mem_read, sm_mem_write, sm_iord, sm_ir_write, sm_pc_write;
    logic [1:0]  sm_pc_src;
    logic        sm_alu_src_imm, sm_alu_op_rtype, sm_reg_write, sm_mem_to_reg;
    logic        sm_halted, sm_illegal;
    logic [1:0]  sm_retired;

    logic [12:0] obs;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_ret = 16'd0;

    assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                  alu_src_imm, alu_op_rtype, reg_write, mem_to_reg, halted, illegal};

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .resume(resume),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_imm(alu_src_imm), .alu_op_rtype(alu_op_rtype),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    multicycle_control_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(sreset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .resume(resume),
        .mem_read(sm_mem_read), .mem_write(sm_mem_write), .iord(sm_iord),
        .ir_write(sm_ir_write), .pc_write(sm_pc_write), .pc_src(sm_pc_src),
        .alu_src_imm(sm_alu_src_imm), .alu_op_rtype(sm_alu_op_rtype),
        .reg_write(sm_reg_write), .mem_to_reg(sm_mem_to_reg), .halted(sm_halted),
        .illegal(sm_illegal), .retired(sm_retired)
    );

    task automatic test_reset();
        reset = 1'b1; sreset = 1'b1; opcode = 6'd0; alu_zero = 1'b0;
        mem_ready = 1'b1; resume = 1'b0;
        #2;
        n_vec++;
        if (obs !== E_ZERO) begin
            n_bad++; $display("FAIL reset_strobes: got %b expected %b", obs, E_ZERO);
        end
        n_vec++;
        if (retired !== 16'd0) begin
            n_bad++; $display("FAIL reset_retired: got %0d expected 0", retired);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [12:0] ev [4] = '{E_FR, E_DEC, E_EXALU, E_WB};
        opcode = 6'd0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL alu cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret = exp_ret + 16'd1;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL alu_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        logic [12:0] ev [7] = '{E_FR, E_DEC, E_EXIMM, E_MLW, E_MLW, E_MLW, E_WBLW};
        logic        rv [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'd35;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rv[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL lw cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret = exp_ret + 16'd1;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_beq();
        logic [12:0] ev [6] = '{E_FR, E_DEC, E_BEQ1, E_FR, E_DEC, E_BEQ0};
        logic        zv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 6'd4; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_zero = zv[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL beq cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret = exp_ret + 16'd2;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL beq_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_back_to_back();
        // ADDI, SW, J with no wait states
        logic [12:0] ev [11] = '{E_FR, E_DEC, E_EXIMM, E_WB,
                                 E_FR, E_DEC, E_EXIMM, E_MSW,
                                 E_FR, E_DEC, E_J};
        logic [5:0]  ov [11] = '{6'd8, 6'd8, 6'd8, 6'd8,
                                 6'd43, 6'd43, 6'd43, 6'd43,
                                 6'd2, 6'd2, 6'd2};
        mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            opcode = ov[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL b2b cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        exp_ret = exp_ret + 16'd3;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL b2b_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_halt();
        logic [12:0] ev [14];
        logic        rs [14];
        logic        rdy [14];
        for (int i = 0; i < 14; i++) begin
            ev[i] = E_HLT; rs[i] = 1'b0; rdy[i] = 1'b1;
        end
        ev[0] = E_FR; ev[1] = E_DEC;
        rs[12] = 1'b1;               // resume while halted
        ev[13] = E_FN; rdy[13] = 1'b0; // back in FETCH, memory not ready
        opcode = 6'd63;
        for (int i = 0; i < 14; i++) begin
            resume = rs[i]; mem_ready = rdy[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL halt cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        resume = 1'b0;
        exp_ret = exp_ret + 16'd1;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL halt_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [12:0] ev [3] = '{E_FR, E_ILL, E_FN};
        logic        rv [3] = '{1'b1, 1'b1, 1'b0};
        opcode = 6'd5;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rv[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL illegal cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL illegal_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [12:0] ev [4] = '{E_FR, E_DEC, E_EXIMM, E_MSW};
        logic        rv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'd43;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rv[i];
            @(negedge clk);
            n_vec++;
            if (obs !== ev[i]) begin
                n_bad++; $display("FAIL rstmid cyc%0d: got %b expected %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        // still in MEM waiting; hit reset between edges
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== E_ZERO) begin
            n_bad++; $display("FAIL rstmid_drop: got %b expected %b", obs, E_ZERO);
        end
        exp_ret = 16'd0;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL rstmid_retired: got %0d expected 0", retired);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (obs !== E_FN) begin
            n_bad++; $display("FAIL rstmid_fetch: got %b expected %b", obs, E_FN);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        logic [12:0] ev [4] = '{E_FR, E_DEC, E_EXALU, E_WB};
        logic [1:0]  sv [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        opcode = 6'd0;
        sreset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                @(negedge clk);
                n_vec++;
                if (obs !== ev[i]) begin
                    n_bad++; $display("FAIL sat_seq ins%0d cyc%0d: got %b expected %b", k, i, obs, ev[i]);
                end
                @(posedge clk); #1;
            end
            n_vec++;
            if (sm_retired !== sv[k]) begin
                n_bad++; $display("FAIL sat_small ins%0d: got %0d expected %0d", k, sm_retired, sv[k]);
            end
        end
        exp_ret = exp_ret + 16'd5;
        n_vec++;
        if (retired !== exp_ret) begin
            n_bad++; $display("FAIL sat_main_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid_mem();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
